// File: rtl/par_serializer.sv
`timescale 1ns/1ps
// Parallel-to-serial converter for the UART transmit path: captures a word,
// computes its parity, and shifts it out LSB- or MSB-first on enabled cycles.
module par_serializer #(
    parameter int  DATA_WIDTH = 8,
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  MSB_FIRST,
    input  logic                  PAR_TYP,
    input  logic                  ser_en,
    input  logic                  ser_clr,
    output logic                  S_DATA,
    output logic                  par_bit,
    output logic                  ser_done,
    output logic                  busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    s_data_q, s_data_d;
    logic                    par_q, par_d;
    logic                    done_q, done_d;

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = d[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic even_par(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    // Next-state logic: abort beats capture, capture beats shift.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        s_data_d = s_data_q;
        par_d    = par_q;
        done_d   = 1'b0;
        if (ser_clr) begin
            state_d  = IDLE;
            cnt_d    = {CNT_W{1'b0}};
            s_data_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (DATA_VALID) begin
                        shreg_d = MSB_FIRST ? bit_rev(P_DATA) : P_DATA;
                        cnt_d   = CNT_W'(DATA_WIDTH);
                        par_d   = even_par(P_DATA) ^ PAR_TYP;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    // Zero-count guard keeps the counter from ever wrapping.
                    if (ser_en && (cnt_q != {CNT_W{1'b0}})) begin
                        s_data_d = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                        cnt_d    = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        state_d = SHIFT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            shreg_q  <= {DATA_WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            s_data_q <= 1'b0;
            par_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            s_data_q <= s_data_d;
            par_q    <= par_d;
            done_q   <= done_d;
        end
    end

    assign S_DATA   = s_data_q;
    assign par_bit  = par_q;
    assign ser_done = done_q;
    assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_par_serializer.sv
`timescale 1ns/1ps
// Directed bench for par_serializer: bit order, parity, stall, abort,
// back-to-back words, asynchronous reset and a 2/8/32-bit width sweep.
module tb_par_serializer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MSB_FIRST = 1'b0;
    logic        PAR_TYP = 1'b0;
    logic        ser_en = 1'b0;
    logic        ser_clr = 1'b0;
    logic [7:0]  p8 = 8'h00;
    logic [1:0]  p2 = 2'b00;
    logic [31:0] p32 = 32'h0;
    logic        dv8 = 1'b0, dv2 = 1'b0, dv32 = 1'b0;
    logic        sd8, pb8, dn8, bz8;
    logic        sd2, pb2, dn2, bz2;
    logic        sd32, pb32, dn32, bz32;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    par_serializer #(.DATA_WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .P_DATA(p8), .DATA_VALID(dv8), .MSB_FIRST(MSB_FIRST),
        .PAR_TYP(PAR_TYP), .ser_en(ser_en), .ser_clr(ser_clr),
        .S_DATA(sd8), .par_bit(pb8), .ser_done(dn8), .busy(bz8)
    );
    par_serializer #(.DATA_WIDTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .P_DATA(p2), .DATA_VALID(dv2), .MSB_FIRST(MSB_FIRST),
        .PAR_TYP(PAR_TYP), .ser_en(ser_en), .ser_clr(ser_clr),
        .S_DATA(sd2), .par_bit(pb2), .ser_done(dn2), .busy(bz2)
    );
    par_serializer #(.DATA_WIDTH(32)) dut32 (
        .CLK(CLK), .RST(RST), .P_DATA(p32), .DATA_VALID(dv32), .MSB_FIRST(MSB_FIRST),
        .PAR_TYP(PAR_TYP), .ser_en(ser_en), .ser_clr(ser_clr),
        .S_DATA(sd32), .par_bit(pb32), .ser_done(dn32), .busy(bz32)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a word to the 8-bit instance for one edge (capture edge).
    task automatic capture8(input logic [7:0] d, input logic msb, input logic pt);
        p8 = d; MSB_FIRST = msb; PAR_TYP = pt; dv8 = 1'b1;
        tick();
        dv8 = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick();
        checks++;
        if ({sd8, pb8, dn8, bz8, sd2, pb2, dn2, bz2, sd32, pb32, dn32, bz32} !== 12'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000000000",
                     {sd8, pb8, dn8, bz8, sd2, pb2, dn2, bz2, sd32, pb32, dn32, bz32});
        end
        RST = 1'b1;
        tick();
    endtask

    // Capture, then stream 8 bits with ser_en high; seq[i] is the i-th bit expected.
    task automatic run_word8(input string name, input logic [7:0] d, input logic msb,
                             input logic pt, input logic [7:0] seq, input logic exp_par);
        ser_en = 1'b0;
        capture8(d, msb, pt);
        checks++;
        if (bz8 !== 1'b1 || pb8 !== exp_par) begin
            errors++;
            $display("FAIL %s_capture: busy=%b par=%b expected busy=1 par=%b", name, bz8, pb8, exp_par);
        end
        ser_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (sd8 !== seq[i] || dn8 !== (i == 7) || bz8 !== (i != 7)) begin
                errors++;
                $display("FAIL %s_bit%0d: S_DATA=%b done=%b busy=%b expected %b %b %b",
                         name, i, sd8, dn8, bz8, seq[i], (i == 7), (i != 7));
            end
        end
        tick();
        checks++;
        if (sd8 !== seq[7] || dn8 !== 1'b0 || bz8 !== 1'b0 || pb8 !== exp_par) begin
            errors++;
            $display("FAIL %s_after: S_DATA=%b done=%b busy=%b par=%b expected %b 0 0 %b",
                     name, sd8, dn8, bz8, pb8, seq[7], exp_par);
        end
        ser_en = 1'b0;
    endtask

    task automatic test_lsb_first();
        run_word8("lsb", 8'hB4, 1'b0, 1'b0, 8'b1011_0100, 1'b0);
    endtask

    task automatic test_msb_first_odd();
        run_word8("msb", 8'hB4, 1'b1, 1'b1, 8'b0010_1101, 1'b1);
    endtask

    task automatic test_stall();
        logic [7:0] seq;
        int dones;
        seq = 8'b1011_0100;
        dones = 0;
        capture8(8'hB4, 1'b0, 1'b0);
        ser_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                ser_en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    if (s == 1) begin
                        p8 = 8'hFF; dv8 = 1'b1;
                    end
                    tick();
                    dv8 = 1'b0;
                    if (dn8) dones++;
                    checks++;
                    if (sd8 !== seq[2] || bz8 !== 1'b1 || dn8 !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold%0d: S_DATA=%b busy=%b done=%b expected %b 1 0",
                                 s, sd8, bz8, dn8, seq[2]);
                    end
                end
                ser_en = 1'b1;
            end
            tick();
            if (dn8) dones++;
            checks++;
            if (sd8 !== seq[i]) begin
                errors++;
                $display("FAIL stall_bit%0d: S_DATA=%b expected %b", i, sd8, seq[i]);
            end
        end
        for (int j = 0; j < 2; j++) begin
            tick();
            if (dn8) dones++;
        end
        checks++;
        if (dones !== 1 || bz8 !== 1'b0 || sd8 !== 1'b1) begin
            errors++;
            $display("FAIL stall_done_once: dones=%0d busy=%b S_DATA=%b expected 1 0 1", dones, bz8, sd8);
        end
        ser_en = 1'b0;
    endtask

    task automatic test_abort();
        logic [7:0] seq;
        seq = 8'b1011_0100;
        capture8(8'hB4, 1'b0, 1'b0);
        ser_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (sd8 !== seq[3] || bz8 !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: S_DATA=%b busy=%b expected %b 1", sd8, bz8, seq[3]);
        end
        ser_clr = 1'b1; p8 = 8'h5A; dv8 = 1'b1;
        tick();
        ser_clr = 1'b0;
        checks++;
        if (bz8 !== 1'b0 || sd8 !== 1'b0 || dn8 !== 1'b0 || pb8 !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b S_DATA=%b done=%b par=%b expected 0 0 0 0", bz8, sd8, dn8, pb8);
        end
        PAR_TYP = 1'b1;
        tick();
        dv8 = 1'b0;
        checks++;
        if (bz8 !== 1'b1 || sd8 !== 1'b0 || pb8 !== 1'b1) begin
            errors++;
            $display("FAIL abort_recapture: busy=%b S_DATA=%b par=%b expected 1 0 1", bz8, sd8, pb8);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (sd8 !== p8[i] || dn8 !== (i == 7)) begin
                errors++;
                $display("FAIL abort_bit%0d: S_DATA=%b done=%b expected %b %b", i, sd8, dn8, p8[i], (i == 7));
            end
        end
        ser_en = 1'b0;
        PAR_TYP = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq;
        int dones;
        seq = 16'b1000_0000_0000_0001;
        dones = 0;
        capture8(8'h01, 1'b0, 1'b0);
        ser_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                capture8(8'h80, 1'b0, 1'b0);
                checks++;
                if (bz8 !== 1'b1 || sd8 !== 1'b0 || dn8 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_capture: busy=%b S_DATA=%b done=%b expected 1 0 0", bz8, sd8, dn8);
                end
            end
            tick();
            if (dn8) dones++;
            checks++;
            if (sd8 !== seq[i] || bz8 !== (i != 7 && i != 15)) begin
                errors++;
                $display("FAIL b2b_bit%0d: S_DATA=%b busy=%b expected %b %b",
                         i, sd8, bz8, seq[i], (i != 7 && i != 15));
            end
        end
        for (int j = 0; j < 3; j++) tick();
        checks++;
        if (dones !== 2 || sd8 !== 1'b1 || bz8 !== 1'b0 || dn8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_en: dones=%0d S_DATA=%b busy=%b done=%b expected 2 1 0 0", dones, sd8, bz8, dn8);
        end
        ser_en = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        capture8(8'hB4, 1'b1, 1'b1);
        ser_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (sd8 !== 1'b1 || bz8 !== 1'b1 || pb8 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: S_DATA=%b busy=%b par=%b expected 1 1 1", sd8, bz8, pb8);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({sd8, pb8, dn8, bz8} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_async: outputs=%b expected 0000", {sd8, pb8, dn8, bz8});
        end
        tick();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (sd8 !== 1'b0 || bz8 !== 1'b0 || dn8 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: S_DATA=%b busy=%b done=%b expected 0 0 0", sd8, bz8, dn8);
        end
        ser_en = 1'b0;
    endtask

    task automatic test_width_sweep();
        logic [31:0] seq32;
        int dones;
        seq32 = 32'h8000_0001;
        MSB_FIRST = 1'b0; PAR_TYP = 1'b0;
        p2 = 2'b10; dv2 = 1'b1;
        tick();
        dv2 = 1'b0;
        checks++;
        if (bz2 !== 1'b1 || pb2 !== 1'b1) begin
            errors++;
            $display("FAIL w2_capture: busy=%b par=%b expected 1 1", bz2, pb2);
        end
        ser_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (sd2 !== p2[i] || dn2 !== (i == 1) || bz2 !== (i == 0)) begin
                errors++;
                $display("FAIL w2_bit%0d: S_DATA=%b done=%b busy=%b expected %b %b %b",
                         i, sd2, dn2, bz2, p2[i], (i == 1), (i == 0));
            end
        end
        for (int j = 0; j < 4; j++) tick();
        checks++;
        if (bz2 !== 1'b0 || dn2 !== 1'b0 || sd2 !== 1'b1) begin
            errors++;
            $display("FAIL w2_nowrap: busy=%b done=%b S_DATA=%b expected 0 0 1", bz2, dn2, sd2);
        end
        ser_en = 1'b0;
        p32 = 32'h8000_0001; dv32 = 1'b1;
        tick();
        dv32 = 1'b0;
        checks++;
        if (bz32 !== 1'b1 || pb32 !== 1'b0) begin
            errors++;
            $display("FAIL w32_capture: busy=%b par=%b expected 1 0", bz32, pb32);
        end
        ser_en = 1'b1;
        dones = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (dn32) dones++;
            checks++;
            if (sd32 !== seq32[i] || bz32 !== (i != 31)) begin
                errors++;
                $display("FAIL w32_bit%0d: S_DATA=%b busy=%b expected %b %b", i, sd32, bz32, seq32[i], (i != 31));
            end
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            if (dn32) dones++;
        end
        checks++;
        if (dones !== 1 || bz32 !== 1'b0 || sd32 !== 1'b1) begin
            errors++;
            $display("FAIL w32_nowrap: dones=%0d busy=%b S_DATA=%b expected 1 0 1", dones, bz32, sd32);
        end
        ser_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first_odd();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid_word();
        test_width_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
